alu_exec_stage: RTL and testbench

// Execute-stage controller in front of the 16-bit ALU. It accepts one operation (A, B, 5-bit code) per valid/ready handshake.
// It drives the ALU operand/code inputs from registers and holds them stable while the ALU settles.
// It then captures C/overflow into output registers with zero/negative/illegal flags and presents them downstream via valid/ready.
// It also keeps a sticky overflow flag and a completed-result counter for the writeback/status logic.

---
 rtl/alu_exec_stage.sv | 137 +++++++++++++
 tb/tb_alu_exec_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute-stage controller for the 16-bit ALU: registers operands, waits for
// the ALU to settle, captures result/flags and hands them off via valid/ready.
module alu_exec_stage #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_a,
    input  logic [15:0]        in_b,
    input  logic [4:0]         in_code,
    output logic [15:0]        alu_a,
    output logic [15:0]        alu_b,
    output logic [4:0]         alu_code,
    input  logic [15:0]        alu_c,
    input  logic               alu_overflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_c,
    output logic               out_overflow,
    output logic               out_zero,
    output logic               out_neg,
    output logic               out_illegal,
    output logic               sticky_ovf,
    input  logic               clr_sticky,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    // One bit per code: 0-5, 8-10, 12, 16-19, 24-29 are supported.
    localparam logic [31:0] LEGAL_MASK = 32'h3F0F_173F;
    localparam logic [3:0]  CNT_INIT   = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       legal;
    logic       capture;
    logic       handoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
        accept    = in_valid & in_ready;
        legal     = LEGAL_MASK[in_code];
        capture   = (state == SETTLE) && (cnt == 4'd0);
        handoff   = out_valid & out_ready;
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = legal ? SETTLE : DONE;
                end else if (handoff) begin
                    state_nxt = IDLE;
                end
            end
            SETTLE: begin
                if (capture) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_code <= '0;
            cnt      <= '0;
        end else if (accept) begin
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_code <= in_code;
            cnt      <= CNT_INIT;
        end else if (state == SETTLE && !capture) begin
            cnt <= cnt - 4'd1;
        end
    end

    // An illegal op skips the ALU and reports a zero result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_c        <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_neg      <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept && !legal) begin
            out_c        <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b1;
            out_neg      <= 1'b0;
            out_illegal  <= 1'b1;
        end else if (capture) begin
            out_c        <= alu_c;
            out_overflow <= alu_overflow;
            out_zero     <= (alu_c == 16'h0000);
            out_neg      <= alu_c[15];
            out_illegal  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            op_count   <= '0;
        end else begin
            if (capture && alu_overflow) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end
            if (handoff) begin
                op_count <= op_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU, transaction-level model and
// directed vectors with hand-computed expectations.
module tb_alu_exec_stage;

    localparam int SETTLE = 2;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_sticky = 1'b0;
    logic [15:0]   in_a = '0;
    logic [15:0]   in_b = '0;
    logic [4:0]    in_code = '0;
    logic          in_ready;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [4:0]    alu_code;
    logic [15:0]   alu_c;
    logic          alu_overflow;
    logic          out_valid;
    logic [15:0]   out_c;
    logic          out_overflow;
    logic          out_zero;
    logic          out_neg;
    logic          out_illegal;
    logic          sticky_ovf;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_exec_stage #(.SETTLE_CYCLES(SETTLE), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_code(in_code),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_c(alu_c), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_overflow(out_overflow),
        .out_zero(out_zero), .out_neg(out_neg),
        .out_illegal(out_illegal), .sticky_ovf(sticky_ovf),
        .clr_sticky(clr_sticky), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, result}.
    function automatic logic [16:0] alu_f(input logic [4:0] code,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        int sa;
        int sb;
        int s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (code)
            5'd0: s = sa + sb;
            5'd1: s = sa - sb;
            5'd4: s = sa + 1;
            5'd5: s = sa - 1;
            default: return {1'b0, a ^ b};
        endcase
        return {(s > 32767 || s < -32768), s[15:0]};
    endfunction

    always_comb {alu_overflow, alu_c} = alu_f(alu_code, alu_a, alu_b);

    function automatic bit legal_code(input logic [4:0] c);
        return c inside {[0:5], [8:10], 12, [16:19], [24:29]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction model: one pending op with edge countdown, one result slot.
    bit          m_busy;
    bit          m_valid;
    int          m_left;
    logic [15:0] m_pc;
    bit          m_povf;
    logic [15:0] m_c;
    bit          m_ovf;
    bit          m_ill;
    bit          m_sticky;
    int          m_count;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [4:0]  m_code;

    function automatic bit m_ready();
        return !m_busy && (!m_valid || out_ready);
    endfunction

    task automatic model_step();
        bit acc;
        bit hand;
        logic [16:0] r;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_left = 0; m_pc = '0; m_povf = 0;
            m_c = '0; m_ovf = 0; m_ill = 0; m_sticky = 0; m_count = 0;
            m_a = '0; m_b = '0; m_code = '0;
        end else begin
            acc  = in_valid && m_ready();
            hand = m_valid && out_ready;
            if (clr_sticky) m_sticky = 0;
            if (hand) begin
                m_count = (m_count + 1) % (1 << CW);
                m_valid = 0;
            end
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy = 0; m_valid = 1;
                    m_c = m_pc; m_ovf = m_povf; m_ill = 0;
                    if (m_povf) m_sticky = 1;
                end else begin
                    m_left--;
                end
            end
            if (acc) begin
                m_a = in_a; m_b = in_b; m_code = in_code;
                if (legal_code(in_code)) begin
                    r = alu_f(in_code, in_a, in_b);
                    m_pc = r[15:0]; m_povf = r[16];
                    m_busy = 1; m_left = SETTLE;
                end else begin
                    m_valid = 1; m_c = '0; m_ovf = 0; m_ill = 1;
                end
            end
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
            chk("op_count", 32'(op_count), 32'(m_count));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_code", 32'(alu_code), 32'(m_code));
            if (m_valid) begin
                chk("out_c", 32'(out_c), 32'(m_c));
                chk("out_overflow", 32'(out_overflow), 32'(m_ovf));
                chk("out_zero", 32'(out_zero), 32'(m_c == 16'h0));
                chk("out_neg", 32'(out_neg), 32'(m_c[15]));
                chk("out_illegal", 32'(out_illegal), 32'(m_ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] c);
        bit done;
        done = 0;
        in_a = a; in_b = b; in_code = c; in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    logic [4:0] codes [16] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd2, 5'd6,
                               5'd7, 5'd31, 5'd8, 5'd12, 5'd16, 5'd24,
                               5'd29, 5'd3, 5'd11, 5'd30};
    logic [CW-1:0] cnt0;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // T1: reset mid-settle discards the op
        out_ready = 1'b1;
        send(16'h0001, 16'h0002, 5'd0);
        rst_n = 1'b0;
        #1;
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_alu_a", 32'(alu_a), 32'd0);
        chk("t1_alu_b", 32'(alu_b), 32'd0);
        chk("t1_out_c", 32'(out_c), 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("t1_no_valid", 32'(out_valid), 32'd0);

        // T2: signed add, exact latency
        out_ready = 1'b0;
        send(16'h8534, 16'h7546, 5'd0);
        chk("t2_lat0", 32'(out_valid), 32'd0);
        step();
        chk("t2_lat1", 32'(out_valid), 32'd0);
        step();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_c", 32'(out_c), 32'h0000_FA7A);
        chk("t2_ovf", 32'(out_overflow), 32'd0);
        chk("t2_neg", 32'(out_neg), 32'd1);
        chk("t2_zero", 32'(out_zero), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // T3: increment overflow
        send(16'h7FFF, 16'h0000, 5'd4);
        step();
        step();
        chk("t3_c", 32'(out_c), 32'h0000_8000);
        chk("t3_ovf", 32'(out_overflow), 32'd1);
        chk("t3_sticky", 32'(sticky_ovf), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // T4: illegal code, sticky untouched
        send(16'h1234, 16'h5678, 5'd6);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_c", 32'(out_c), 32'd0);
        chk("t4_illegal", 32'(out_illegal), 32'd1);
        chk("t4_zero", 32'(out_zero), 32'd1);
        chk("t4_sticky", 32'(sticky_ovf), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("t3_clear", 32'(sticky_ovf), 32'd0);

        // Set and clear on the capture edge: set wins
        clr_sticky = 1'b1;
        send(16'h7FFF, 16'h0000, 5'd4);
        step();
        step();
        clr_sticky = 1'b0;
        chk("set_wins", 32'(sticky_ovf), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;

        // T5: backpressure then back-to-back accept
        send(16'h0003, 16'h0004, 5'd0);
        step();
        step();
        in_a = 16'd10; in_b = 16'd20; in_code = 5'd1; in_valid = 1'b1;
        repeat (5) begin
            #1;
            chk("t5_hold_ready", 32'(in_ready), 32'd0);
            chk("t5_hold_c", 32'(out_c), 32'd7);
            step();
        end
        cnt0 = op_count;
        out_ready = 1'b1;
        #1;
        chk("t5_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("t5_count", 32'(op_count), 32'(CW'(cnt0 + 1'b1)));
        chk("t5_alu_a", 32'(alu_a), 32'd10);
        chk("t5_settle", 32'(out_valid), 32'd0);
        step();
        step();
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_c", 32'(out_c), 32'h0000_FFF6);
        step();

        // T6: 16 handoffs wrap a 4-bit counter
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(16'(i * 4099), 16'(i * 3), codes[i]);
        end
        repeat (4) step();
        chk("t6_wrap", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
